// File: rtl/reg_count_mod_pkg.sv
// Shared definitions for the parametrised counter register and its step unit.
package reg_count_mod_pkg;

  localparam logic DIR_UP    = 1'b1;
  localparam logic DIR_DN    = 1'b0;
  localparam logic MODE_WRAP = 1'b0;
  localparam logic MODE_SAT  = 1'b1;

  localparam int WIDTH_MIN = 2;
  localparam int WIDTH_MAX = 16;

endpackage

// File: rtl/reg_count_mod_step_n.sv
// WIDTH-bit increment/decrement by one; carry/borrow out is dropped.
module step_n
  import reg_count_mod_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] A,
  input  logic             dir,
  output logic [WIDTH-1:0] S
);

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  assign S = (dir == DIR_UP) ? A + ONE : A - ONE;

endmodule

// File: rtl/reg_count_mod.sv
// Up/down counter register with load, programmable terminal value,
// wrap/saturate mode, terminal-count strobe and sticky overflow flag.
module reg_count_mod
  import reg_count_mod_pkg::*;
#(
  parameter int          WIDTH     = 4,
  parameter int unsigned RESET_VAL = 0
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] loadVal,
  input  logic             dir,
  input  logic             sat,
  input  logic [WIDTH-1:0] maxVal,
  input  logic             clrOvf,
  output logic [WIDTH-1:0] Q,
  output logic             tc,
  output logic             ovf
);

  generate
    if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX || RESET_VAL >= (32'd1 << WIDTH)) begin : g_bad_param
      $error("reg_count_mod: illegal WIDTH or RESET_VAL");
    end
  endgenerate

  localparam logic [WIDTH-1:0] RST_Q = RESET_VAL[WIDTH-1:0];

  logic [WIDTH-1:0] stepped;
  logic [WIDTH-1:0] q_nxt;
  logic             ovf_nxt;
  logic             at_top;
  logic             at_zero;
  logic             above;

  step_n #(.WIDTH(WIDTH)) u_step (
    .A   (Q),
    .dir (dir),
    .S   (stepped)
  );

  assign at_top  = (Q >= maxVal);
  assign at_zero = (Q == '0);
  assign above   = (Q > maxVal);

  // Terminal event: the edge at the end of this cycle wraps or saturates.
  assign tc = en & ~load & ((dir == DIR_UP) ? at_top : at_zero);

  always_comb begin
    q_nxt   = Q;
    ovf_nxt = ovf;
    if (load) begin
      q_nxt   = (loadVal > maxVal) ? maxVal : loadVal;
      ovf_nxt = 1'b0;
    end else begin
      if (en) begin
        if (dir == DIR_UP) begin
          if (at_top) q_nxt = (sat == MODE_SAT) ? maxVal : '0;
          else        q_nxt = stepped;
        end else begin
          // A shrunken maxVal snaps a down-count back into range first.
          if (above)        q_nxt = maxVal;
          else if (at_zero) q_nxt = (sat == MODE_SAT) ? '0 : maxVal;
          else              q_nxt = stepped;
        end
      end
      if (tc)          ovf_nxt = 1'b1;
      else if (clrOvf) ovf_nxt = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      Q   <= RST_Q;
      ovf <= 1'b0;
    end else begin
      Q   <= q_nxt;
      ovf <= ovf_nxt;
    end
  end

endmodule

// File: tb/tb_reg_count_mod.sv
// Randomised and directed checks of reg_count_mod against an integer model.
module tb_reg_count_mod;

  localparam int W  = 4;
  localparam int RV = 0;

  logic         clk = 1'b0;
  logic         rstn;
  logic         en, load, dir, sat, clrOvf;
  logic [W-1:0] loadVal, maxVal;
  logic [W-1:0] Q;
  logic         tc, ovf;

  int vectors = 0;
  int miscompares = 0;

  int mq;
  bit mov;

  reg_count_mod #(.WIDTH(W), .RESET_VAL(RV)) dut (
    .clk(clk), .rstn(rstn), .en(en), .load(load), .loadVal(loadVal),
    .dir(dir), .sat(sat), .maxVal(maxVal), .clrOvf(clrOvf),
    .Q(Q), .tc(tc), .ovf(ovf)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "timeout");
  end

  function automatic bit model_tc();
    int mx = int'(maxVal);
    if (!en || load) return 1'b0;
    return dir ? (mq >= mx) : (mq == 0);
  endfunction

  function automatic void model_edge();
    int mx = int'(maxVal);
    bit term;
    if (load) begin
      mq  = (int'(loadVal) > mx) ? mx : int'(loadVal);
      mov = 1'b0;
      return;
    end
    term = model_tc();
    if (en) begin
      if (dir) mq = term ? (sat ? mx : 0) : mq + 1;
      else if (mq > mx) mq = mx;
      else if (term) mq = sat ? 0 : mx;
      else mq = mq - 1;
    end
    if (term) mov = 1'b1;
    else if (clrOvf) mov = 1'b0;
  endfunction

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle();
    en = 0; load = 0; dir = 1; sat = 0; clrOvf = 0; loadVal = '0; maxVal = '1;
  endtask

  task automatic do_load(input int v, input int mx);
    load = 1; loadVal = W'(v); maxVal = W'(mx);
    tick();
    load = 0;
  endtask

  task automatic test_reset();
    idle();
    rstn = 0;
    #3;
    mq = RV; mov = 0;
    vectors++;
    if (Q !== W'(RV) || ovf !== 1'b0 || tc !== 1'b0) begin
      miscompares++;
      $display("FAIL reset: Q=%0d ovf=%b tc=%b want Q=%0d ovf=0 tc=0", Q, ovf, tc, RV);
    end
    @(negedge clk);
    rstn = 1;
  endtask

  task automatic test_wrap_up();
    idle(); en = 1; dir = 1; sat = 0; maxVal = 15;
    for (int i = 0; i < 17; i++) begin
      #1;
      vectors++;
      if (tc !== model_tc() || tc !== (Q == 4'd15)) begin
        miscompares++;
        $display("FAIL wrap_up tc: Q=%0d tc=%b want %b", Q, tc, model_tc());
      end
      tick();
      vectors++;
      if (Q !== W'(mq) || ovf !== mov) begin
        miscompares++;
        $display("FAIL wrap_up: Q=%0d ovf=%b want Q=%0d ovf=%b", Q, ovf, mq, mov);
      end
    end
    vectors++;
    if (Q !== 4'd1 || ovf !== 1'b1) begin
      miscompares++;
      $display("FAIL wrap_up end: Q=%0d ovf=%b want Q=1 ovf=1", Q, ovf);
    end
  endtask

  task automatic test_sat_up();
    idle(); do_load(0, 9);
    en = 1; dir = 1; sat = 1; maxVal = 9;
    for (int i = 0; i < 12; i++) begin
      #1;
      vectors++;
      if (tc !== (mq == 9)) begin
        miscompares++;
        $display("FAIL sat_up tc: Q=%0d tc=%b want %b", Q, tc, mq == 9);
      end
      tick();
    end
    vectors++;
    if (Q !== 4'd9 || ovf !== 1'b1) begin
      miscompares++;
      $display("FAIL sat_up: Q=%0d ovf=%b want Q=9 ovf=1", Q, ovf);
    end
  endtask

  task automatic test_down_wrap();
    idle(); do_load(1, 5);
    en = 1; dir = 0; sat = 0; maxVal = 5;
    #1;
    vectors++;
    if (tc !== 1'b0) begin
      miscompares++;
      $display("FAIL down_wrap tc@1: got %b want 0", tc);
    end
    tick();
    vectors++;
    if (Q !== 4'd0 || tc !== 1'b1) begin
      miscompares++;
      $display("FAIL down_wrap step1: Q=%0d tc=%b want Q=0 tc=1", Q, tc);
    end
    tick();
    vectors++;
    if (Q !== 4'd5 || ovf !== 1'b1) begin
      miscompares++;
      $display("FAIL down_wrap step2: Q=%0d ovf=%b want Q=5 ovf=1", Q, ovf);
    end
  endtask

  task automatic test_load_clamp();
    idle();
    en = 1; load = 1; loadVal = 12; maxVal = 7;
    tick();
    load = 0; en = 0;
    vectors++;
    if (Q !== 4'd7 || ovf !== 1'b0) begin
      miscompares++;
      $display("FAIL load_clamp: Q=%0d ovf=%b want Q=7 ovf=0", Q, ovf);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      vectors++;
      if (Q !== 4'd7 || tc !== 1'b0) begin
        miscompares++;
        $display("FAIL load_hold: Q=%0d tc=%b want Q=7 tc=0", Q, tc);
      end
    end
  endtask

  task automatic test_ovf_clear();
    idle(); do_load(3, 3);
    en = 1; dir = 1; sat = 1; maxVal = 3;
    tick();
    clrOvf = 1;
    #1;
    vectors++;
    if (ovf !== 1'b1 || tc !== 1'b1) begin
      miscompares++;
      $display("FAIL ovf_pre: ovf=%b tc=%b want 1 1", ovf, tc);
    end
    tick();
    vectors++;
    if (ovf !== 1'b1 || Q !== 4'd3) begin
      miscompares++;
      $display("FAIL ovf_set_wins: ovf=%b Q=%0d want ovf=1 Q=3", ovf, Q);
    end
    en = 0;
    tick();
    clrOvf = 0;
    vectors++;
    if (ovf !== 1'b0) begin
      miscompares++;
      $display("FAIL ovf_clear: ovf=%b want 0", ovf);
    end
  endtask

  task automatic test_async_reset();
    idle(); do_load(0, 15);
    en = 1; dir = 1; sat = 0; maxVal = 15;
    for (int i = 0; i < 6; i++) tick();
    vectors++;
    if (Q !== 4'd6) begin
      miscompares++;
      $display("FAIL async_pre: Q=%0d want 6", Q);
    end
    #1 rstn = 0;
    #1;
    mq = RV; mov = 0;
    vectors++;
    if (Q !== W'(RV) || ovf !== 1'b0) begin
      miscompares++;
      $display("FAIL async_reset: Q=%0d ovf=%b want Q=%0d ovf=0", Q, ovf, RV);
    end
    @(negedge clk);
    rstn = 1;
    tick();
    vectors++;
    if (Q !== W'(RV + 1)) begin
      miscompares++;
      $display("FAIL async_resume: Q=%0d want %0d", Q, RV + 1);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      en      = ($urandom_range(0, 9) < 8);
      load    = ($urandom_range(0, 19) == 0);
      dir     = $urandom_range(0, 1);
      sat     = ($urandom_range(0, 3) == 0);
      clrOvf  = ($urandom_range(0, 7) == 0);
      loadVal = W'($urandom);
      if ($urandom_range(0, 15) == 0) maxVal = W'($urandom_range(0, 1) ? 0 : $urandom);
      #1;
      vectors++;
      if (tc !== model_tc()) begin
        miscompares++;
        $display("FAIL rand_tc[%0d]: tc=%b want %b (Q=%0d max=%0d)", i, tc, model_tc(), Q, maxVal);
      end
      tick();
      vectors++;
      if (Q !== W'(mq) || ovf !== mov) begin
        miscompares++;
        $display("FAIL rand[%0d]: Q=%0d ovf=%b want Q=%0d ovf=%b", i, Q, ovf, mq, mov);
      end
    end
  endtask

  initial begin
    test_reset();
    test_wrap_up();
    test_sat_up();
    test_down_wrap();
    test_load_clamp();
    test_ovf_clear();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
